// File: rtl/binary_calc_serial_rx_if.sv
// binary_calc_serial_rx_if: serial link, handshake and unpacked-field bundle for the calculator receiver
// master: drives d_in/d_in_valid/clk_rx (link) and data_ack (consumer)
// slave : the receiver; returns data_out, fields a/b/alu/sel/flag, data_ready, rx_busy, frame_err, overrun
interface binary_calc_serial_rx_if #(parameter int WIDTH = 32);
    logic             d_in;
    logic             d_in_valid;
    logic             clk_rx;
    logic             data_ack;
    logic [WIDTH-1:0] data_out;
    logic [7:0]       a_out;
    logic [7:0]       b_out;
    logic [7:0]       alu_out;
    logic [3:0]       sel_out;
    logic [3:0]       flag_out;
    logic             data_ready;
    logic             rx_busy;
    logic             frame_err;
    logic             overrun;
    modport master (
        output d_in, d_in_valid, clk_rx, data_ack,
        input  data_out, a_out, b_out, alu_out, sel_out, flag_out,
               data_ready, rx_busy, frame_err, overrun
    );
    modport slave (
        input  d_in, d_in_valid, clk_rx, data_ack,
        output data_out, a_out, b_out, alu_out, sel_out, flag_out,
               data_ready, rx_busy, frame_err, overrun
    );
endinterface

// File: rtl/binary_calc_serial_rx.sv
// binary_calc_serial_rx: deserialises MSB-first frames from the calculator link and holds them with READY/ACK
// clk   : system clock, rising edge
// rst_n : asynchronous active-low reset
// bus   : slave side of binary_calc_serial_rx_if (link inputs, ack, word/fields, status pulses)
module binary_calc_serial_rx #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input logic                    clk,
    input logic                    rst_n,
    binary_calc_serial_rx_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_LOW} state_t;

    state_t           state, state_nxt;
    logic [SYNC_STAGES-1:0] d_q, v_q, c_q;
    logic             d_s, v_s, c_s, c_prev, bit_tick;
    logic             shift_en, err_set, done_set, done;
    logic [WIDTH-1:0] shreg, data_out;
    logic [CW-1:0]    cnt;
    logic             data_ready, frame_err, overrun;

    assign d_s      = d_q[SYNC_STAGES-1];
    assign v_s      = v_q[SYNC_STAGES-1];
    assign c_s      = c_q[SYNC_STAGES-1];
    assign bit_tick = c_s & ~c_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q    <= '0;
            v_q    <= '0;
            c_q    <= '0;
            c_prev <= 1'b0;
        end else begin
            d_q    <= SYNC_STAGES'({d_q, bus.d_in});
            v_q    <= SYNC_STAGES'({v_q, bus.d_in_valid});
            c_q    <= SYNC_STAGES'({c_q, bus.clk_rx});
            c_prev <= c_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:     state_nxt = v_s ? SHIFT : IDLE;
            SHIFT:    state_nxt = !v_s ? IDLE : done_set ? WAIT_LOW : SHIFT;
            WAIT_LOW: state_nxt = v_s ? WAIT_LOW : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // A tick arriving with the valid that opens the frame is already bit 0;
    // in SHIFT a valid drop outranks a coincident tick.
    always_comb begin
        shift_en = bit_tick & v_s & (state == IDLE || state == SHIFT);
        err_set  = (state == SHIFT) & ~v_s;
        done_set = (state == SHIFT) & shift_en & (cnt == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            cnt       <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (shift_en) shreg <= {shreg[WIDTH-2:0], d_s};
            cnt       <= (state != SHIFT) ? CW'(shift_en) : (shift_en && cnt != LAST) ? cnt + 1'b1 : cnt;
            done      <= done_set;
            frame_err <= err_set;
        end
    end

    // Load one cycle after the final shift so the last bit is already in shreg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_ready <= 1'b0;
            overrun    <= 1'b0;
        end else if (done) begin
            data_out   <= shreg;
            data_ready <= 1'b1;
            overrun    <= data_ready & ~bus.data_ack;
        end else begin
            data_ready <= data_ready & ~bus.data_ack;
            overrun    <= 1'b0;
        end
    end

    assign bus.data_out   = data_out;
    assign bus.a_out      = data_out[31:24];
    assign bus.b_out      = data_out[23:16];
    assign bus.alu_out    = data_out[15:8];
    assign bus.sel_out    = data_out[7:4];
    assign bus.flag_out   = data_out[3:0];
    assign bus.data_ready = data_ready;
    assign bus.rx_busy    = (state == SHIFT);
    assign bus.frame_err  = frame_err;
    assign bus.overrun    = overrun;
endmodule

// File: tb/tb_binary_calc_serial_rx.sv
// tb_binary_calc_serial_rx: directed-vector bench for binary_calc_serial_rx
module tb_binary_calc_serial_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   fe_cnt = 0;
    int   ov_cnt = 0;
    int   rdy_rises = 0;
    logic rdy_q = 1'b0;
    time  t_rise = 0;
    time  t_ready = 0;

    binary_calc_serial_rx_if #(.WIDTH(32)) bus ();

    binary_calc_serial_rx #(.WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        fe_cnt    += int'(bus.frame_err);
        ov_cnt    += int'(bus.overrun);
        if (bus.data_ready && !rdy_q) begin
            rdy_rises += 1;
            t_ready    = $time;
        end
        rdy_q = bus.data_ready;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Sends nbits of w MSB first, then extra filler ticks; hp = half bit period in clk cycles.
    task automatic send(input logic [31:0] w, input int nbits, input int extra, input int hp,
                        input bit ack_load, input bit drop);
        bus.d_in_valid = 1'b1;
        for (int i = 0; i < nbits + extra; i++) begin
            bus.d_in = (i < 32) ? w[31-i] : i[0];
            repeat (hp) @(negedge clk);
            bus.clk_rx = 1'b1;
            if (i == nbits - 1) t_rise = $time;
            if (i == nbits - 1 && ack_load) begin
                repeat (3) @(negedge clk);
                bus.data_ack = 1'b1;
                @(negedge clk);
                bus.data_ack = 1'b0;
                repeat (hp) @(negedge clk);
            end else begin
                repeat (hp) @(negedge clk);
            end
            bus.clk_rx = 1'b0;
        end
        if (drop) begin
            bus.d_in_valid = 1'b0;
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic ack;
        bus.data_ack = 1'b1;
        @(negedge clk);
        bus.data_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.d_in = 1'b0;
        bus.d_in_valid = 1'b0;
        bus.clk_rx = 1'b0;
        bus.data_ack = 1'b0;
        #1;
        check("rst_data", bus.data_out, 32'h0);
        check("rst_ready", 32'(bus.data_ready), 32'h0);
        check("rst_busy", 32'(bus.rx_busy), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send(32'h12344600, 32, 0, 2, 1'b0, 1'b1);
        check("t1_ready", 32'(bus.data_ready), 32'h1);
        check("t1_lat", 32'((t_ready - t_rise) / 10), 32'd4);
        check("t1_a", 32'(bus.a_out), 32'h12);
        check("t1_b", 32'(bus.b_out), 32'h34);
        check("t1_alu", 32'(bus.alu_out), 32'h46);
        check("t1_sel", 32'(bus.sel_out), 32'h0);
        check("t1_flag", 32'(bus.flag_out), 32'h0);
        ack();
        check("t1_ack", 32'(bus.data_ready), 32'h0);

        fe_cnt = 0;
        send(32'hDEADBEEF, 17, 0, 2, 1'b0, 1'b1);
        check("t2_ferr", 32'(fe_cnt), 32'd1);
        check("t2_ready", 32'(bus.data_ready), 32'h0);
        send(32'hFFFFFFFF, 32, 0, 2, 1'b0, 1'b1);
        check("t2_data", bus.data_out, 32'hFFFFFFFF);
        check("t2_ready2", 32'(bus.data_ready), 32'h1);
        check("t2_ferr2", 32'(fe_cnt), 32'd1);
        ack();

        ov_cnt = 0;
        send(32'h0000000F, 32, 0, 2, 1'b0, 1'b1);
        check("t3_flag", 32'(bus.flag_out), 32'hF);
        send(32'hF0000000, 32, 0, 2, 1'b0, 1'b1);
        check("t3_ovr", 32'(ov_cnt), 32'd1);
        check("t3_data", bus.data_out, 32'hF0000000);
        check("t3_ready", 32'(bus.data_ready), 32'h1);
        ov_cnt = 0;
        send(32'h0000000F, 32, 0, 4, 1'b1, 1'b1);
        check("t3_ovr_ack", 32'(ov_cnt), 32'd0);
        check("t3_data2", bus.data_out, 32'h0000000F);
        check("t3_ready2", 32'(bus.data_ready), 32'h1);
        ack();

        rdy_rises = 0;
        ov_cnt = 0;
        send(32'hA5A5A5A5, 32, 40, 2, 1'b0, 1'b1);
        check("t4_data", bus.data_out, 32'hA5A5A5A5);
        check("t4_rises", 32'(rdy_rises), 32'd1);
        check("t4_ovr", 32'(ov_cnt), 32'd0);

        fe_cnt = 0;
        send(32'h55555555, 10, 0, 2, 1'b0, 1'b0);
        check("t5_busy_mid", 32'(bus.rx_busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("t5_data", bus.data_out, 32'h0);
        check("t5_ready", 32'(bus.data_ready), 32'h0);
        check("t5_busy", 32'(bus.rx_busy), 32'h0);
        bus.d_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_ferr", 32'(fe_cnt), 32'd0);
        send(32'h80000001, 32, 0, 2, 1'b0, 1'b1);
        check("t5_data2", bus.data_out, 32'h80000001);
        check("t5_ferr2", 32'(fe_cnt), 32'd0);
        ack();

        send(32'h03050800, 32, 0, 4, 1'b0, 1'b1);
        check("t6_a", 32'(bus.a_out), 32'h03);
        check("t6_b", 32'(bus.b_out), 32'h05);
        check("t6_alu", 32'(bus.alu_out), 32'h08);
        check("t6_ready", 32'(bus.data_ready), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
